video_capture_rx: RTL and testbench
===================================

# video_capture_rx

Receive-side counterpart of the VGA output path. Takes a camera-style pixel stream (vsync, href, 8-bit RGB565 byte pairs), recovers frame/line/pixel position, packs each byte pair into a 12-bit Basys3 color word, and emits linear frame-buffer write strobes. Sits between the camera pins (already in `pixel_clk`'s domain) and the frame-buffer BRAM that feeds the face-detection pipeline and the VGA interface.

## Interface
Parameters:
- `WIDTH_COLOR`, 12: output color width; must be a multiple of three (4 bits per channel).
- `WIDTH_POS`, 10: width of `xpos` and `ypos`.
- `H_ACTIVE`, 640: pixels per captured line.
- `V_ACTIVE`, 480: lines per captured frame.
- `WIDTH_ADDR`, 19: frame-buffer address width; the integrator sets it to 17 when `DOWNSCALE_EN` is defined.

Ports:
- `pixel_clk`  in  1  only clock; all inputs are sampled on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `vsync_in`  in  1  high during vertical blanking.
- `href_in`  in  1  high while line bytes are valid.
- `data_in`  in  8  RGB565 byte stream, high byte first.
- `wr_en`  out  1  one-cycle frame-buffer write strobe.
- `wr_addr`  out  WIDTH_ADDR  linear write address.
- `wr_data`  out  WIDTH_COLOR  packed {R,G,B} pixel.
- `xpos`, `ypos`  out  WIDTH_POS  position of the pixel on `wr_data`.
- `busy`  out  1  high in CAPTURE.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `frame_err`  out  1  valid with `frame_done`; high if the frame was malformed.

## Operation
- All three inputs pass through one register stage (`vsync_q`, `href_q`, `data_q`). All logic below acts on the registered copies.
- FSM states:
  - WAIT_VS: wait for `vsync_q`=1, then go to ARM.
  - ARM: wait for a `vsync_q` falling edge. On that edge, clear the line, pixel and address counters, clear the error flag, and go to CAPTURE.
  - CAPTURE: capture lines. A `vsync_q` rising edge goes to DONE.
  - DONE: lasts one cycle. Pulses `frame_done` with `frame_err`, then goes to ARM.
- Byte phase:
  - Cleared at each `href_q` rising edge and toggles on every `href_q`=1 cycle.
  - Phase 0 latches the high byte; phase 1 completes the pixel.
- Packing from RGB565 to 444:
  - R = hi[7:4]
  - G = {hi[2:0], lo[7]}
  - B = lo[4:1]
- Line handling:
  - On each `href_q` falling edge, the line counter increments and the pixel counter clears.
  - If the phase is 1 at the falling edge, the trailing half pixel is dropped and the error flag is set.
  - If the line's pixel count is not `H_ACTIVE`, the error flag is set.
- Writes are suppressed when x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE`. The counters keep running, saturating at their maximum.
- The address is an incrementing counter: +1 per written pixel, cleared at frame start. There is no multiplier.
- At DONE, a line count other than `V_ACTIVE` sets `frame_err`.
- `href_q`=1 while `vsync_q`=1, or outside CAPTURE, is ignored.

## Timing
- Reset value of every output is 0. The FSM resets to WAIT_VS.
- Reset mid-frame discards that frame. Capture restarts only after a full vsync high→low sequence.
- Latency: if the low byte is on `data_in` at edge N, then `wr_en`, `wr_addr`, `wr_data`, `xpos` and `ypos` are valid after edge N+2. `wr_en` is high for exactly one cycle per pixel.
- Maximum write rate is one pixel every 2 cycles.
- `frame_done` asserts 2 cycles after the `vsync_in` rising edge is presented.
- If a vsync rising edge arrives in the same cycle as a pending pixel write, the write completes first, then DONE is entered.

## Configuration
- `VIDEO_CAPTURE_DOWNSCALE_EN` defined:
  - Only pixels with even x and even y are written; all others are discarded.
  - The address counter steps once per kept pixel, giving a (`H_ACTIVE`/2)×(`V_ACTIVE`/2) image; `xpos` and `ypos` report the halved coordinates.
  - Error checks still use the full `H_ACTIVE` and `V_ACTIVE`.
- Undefined: every pixel is written at full resolution.

## Structure
- Shared package `video_pkg`:
  - the FSM state enum;
  - the RGB565→444 bit-slice constants;
  - default `H_ACTIVE`/`V_ACTIVE`, which are shared with the VGA controller.
- One sub-module, `rgb565_packer`: byte phase plus 444 packing, producing `pix_valid` and `pix_data`.
- The FSM and counters live in the top level.

## Test plan
- Reset, then a 640×480 frame with pixel value hi=0xF8, lo=0x1F → 307200 `wr_en` pulses; `wr_data`=0xF0F; last `wr_addr`=307199; `frame_done`=1, `frame_err`=0.
- Line 5 with 641 pixels → the extra pixel is not written, line 6 starts at address 3840, and `frame_err`=1 at `frame_done`.
- Line with an odd byte count (1279 bytes) → the last half pixel is dropped and `frame_err`=1.
- `rst_n` low for 1 cycle mid-line 100 → outputs are 0 immediately. There are no writes until vsync high→low, and the next frame starts at `wr_addr`=0.
- `href_in` pulses while `vsync_in`=1 → no `wr_en`.
- With `VIDEO_CAPTURE_DOWNSCALE_EN`: a full frame → 76800 writes, last `wr_addr`=76799, `xpos`/`ypos` max 319/239.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: definitions shared by the capture path and the VGA controller.
package video_pkg;

    // Default active frame geometry, shared with the VGA timing generator.
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // RGB565 -> 444 bit slices. hi = first byte on the bus, lo = second byte.
    localparam int RGB_R_MSB    = 7;   // R = hi[7:4]
    localparam int RGB_R_LSB    = 4;
    localparam int RGB_G_HI_MSB = 2;   // G = {hi[2:0], lo[7]}
    localparam int RGB_G_HI_LSB = 0;
    localparam int RGB_G_LO_BIT = 7;
    localparam int RGB_B_MSB    = 4;   // B = lo[4:1]
    localparam int RGB_B_LSB    = 1;
    localparam int RGB_CH_BITS  = 4;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_WAIT_VS  = 2'd0,
        ST_ARM      = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } cap_state_t;

endpackage

// File: rtl/rgb565_packer.sv
// rgb565_packer: byte-phase tracking and RGB565 -> 444 packing.
// Emits one pix_valid per completed byte pair, plus a line_end pulse one
// cycle after href drops (so it never coincides with the last pixel) and
// line_odd when that line ended on a dangling high byte.
module rgb565_packer
    import video_pkg::*;
#(
    parameter int WIDTH_COLOR = 12
) (
    input  logic                   pixel_clk,
    input  logic                   rst_n,
    input  logic                   href,
    input  logic [7:0]             data,
    output logic                   pix_valid,
    output logic [WIDTH_COLOR-1:0] pix_data,
    output logic                   line_end,
    output logic                   line_odd
);

    localparam int CH = WIDTH_COLOR / 3;

    logic       href_prev;
    logic       phase;
    logic       phase_now;
    logic [7:0] hi_byte;
    logic [RGB_CH_BITS-1:0] r4, g4, b4;
    logic [CH-1:0]          r_c, g_c, b_c;
    logic       unused_bits;

    // A rising href restarts the pair on the high byte.
    assign phase_now = (href && !href_prev) ? 1'b0 : phase;

    assign r4 = hi_byte[RGB_R_MSB:RGB_R_LSB];
    assign g4 = {hi_byte[RGB_G_HI_MSB:RGB_G_HI_LSB], data[RGB_G_LO_BIT]};
    assign b4 = data[RGB_B_MSB:RGB_B_LSB];

    // 4-bit channels are MSB-aligned into CH bits (identity at CH = 4).
    assign r_c = CH'({r4, 28'b0} >> (32 - CH));
    assign g_c = CH'({g4, 28'b0} >> (32 - CH));
    assign b_c = CH'({b4, 28'b0} >> (32 - CH));

    assign unused_bits = hi_byte[3];

    // Byte phase, high-byte latch, pixel completion and line-end reporting.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            href_prev <= 1'b0;
            phase     <= 1'b0;
            hi_byte   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            line_end  <= 1'b0;
            line_odd  <= 1'b0;
        end else begin
            href_prev <= href;
            pix_valid <= 1'b0;
            line_end  <= 1'b0;
            if (href) begin
                if (!phase_now) begin
                    hi_byte <= data;
                    phase   <= 1'b1;
                end else begin
                    pix_valid <= 1'b1;
                    pix_data  <= {r_c, g_c, b_c};
                    phase     <= 1'b0;
                end
            end
            if (!href && href_prev) begin
                line_end <= 1'b1;
                line_odd <= phase;
                phase    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_capture_rx.sv
// video_capture_rx: camera pixel stream -> linear frame-buffer writes.
// Optional build macro VIDEO_CAPTURE_DOWNSCALE_EN keeps only even x / even y
// pixels and reports halved coordinates; error checks stay full-size.
module video_capture_rx
    import video_pkg::*;
#(
    parameter int WIDTH_COLOR = 12,
    parameter int WIDTH_POS   = 10,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int WIDTH_ADDR  = 19
) (
    input  logic                   pixel_clk,
    input  logic                   rst_n,
    input  logic                   vsync_in,
    input  logic                   href_in,
    input  logic [7:0]             data_in,
    output logic                   wr_en,
    output logic [WIDTH_ADDR-1:0]  wr_addr,
    output logic [WIDTH_COLOR-1:0] wr_data,
    output logic [WIDTH_POS-1:0]   xpos,
    output logic [WIDTH_POS-1:0]   ypos,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err
);

    localparam logic [WIDTH_POS-1:0] H_LIM   = WIDTH_POS'(H_ACTIVE);
    localparam logic [WIDTH_POS-1:0] V_LIM   = WIDTH_POS'(V_ACTIVE);
    localparam logic [WIDTH_POS-1:0] POS_MAX = '1;

    logic                   vsync_q, href_q, vsync_prev;
    logic [7:0]             data_q;
    cap_state_t             state, state_next;
    logic                   frame_start;
    logic                   href_gated;
    logic                   pix_valid;
    logic [WIDTH_COLOR-1:0] pix_data;
    logic                   line_end, line_odd;
    logic [WIDTH_POS-1:0]   x_cnt, y_cnt, y_final;
    logic [WIDTH_POS-1:0]   x_out, y_out;
    logic [WIDTH_ADDR-1:0]  addr;
    logic                   err, line_bad, keep;

    // Input register stage; everything downstream uses the _q copies.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_q    <= vsync_in;
            href_q     <= href_in;
            data_q     <= data_in;
            vsync_prev <= vsync_q;
        end
    end

    // State register.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) state <= ST_WAIT_VS;
        else        state <= state_next;
    end

    // Next-state: arm on vsync high, start on its fall, close on its rise.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            ST_WAIT_VS: if (vsync_q) state_next = ST_ARM;
            ST_ARM: begin
                if (vsync_prev && !vsync_q) begin
                    state_next  = ST_CAPTURE;
                    frame_start = 1'b1;
                end
            end
            ST_CAPTURE: if (vsync_q && !vsync_prev) state_next = ST_DONE;
            ST_DONE:    state_next = ST_ARM;
            default:    state_next = ST_WAIT_VS;
        endcase
    end

    assign busy = (state == ST_CAPTURE);

    // href during blanking or outside capture never reaches the packer.
    assign href_gated = href_q && !vsync_q && (state == ST_CAPTURE);

    rgb565_packer #(
        .WIDTH_COLOR (WIDTH_COLOR)
    ) u_packer (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .href      (href_gated),
        .data      (data_q),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .line_end  (line_end),
        .line_odd  (line_odd)
    );

    // Write qualification, line error and the saturating line count at a line end.
    always_comb begin
        keep = (x_cnt < H_LIM) && (y_cnt < V_LIM);
`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
        keep = keep && !x_cnt[0] && !y_cnt[0];
`endif
        line_bad = line_end && (line_odd || (x_cnt != H_LIM));
        y_final  = y_cnt;
        if (line_end && (y_cnt != POS_MAX)) y_final = y_cnt + WIDTH_POS'(1);
    end

`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    assign x_out = x_cnt >> 1;
    assign y_out = y_cnt >> 1;
`else
    assign x_out = x_cnt;
    assign y_out = y_cnt;
`endif

    // Pixel/line/address counters and the sticky frame error flag.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            addr  <= '0;
            err   <= 1'b0;
        end else if (frame_start) begin
            x_cnt <= '0;
            y_cnt <= '0;
            addr  <= '0;
            err   <= 1'b0;
        end else begin
            if (pix_valid) begin
                if (keep) addr <= addr + WIDTH_ADDR'(1);
                if (x_cnt != POS_MAX) x_cnt <= x_cnt + WIDTH_POS'(1);
            end
            if (line_end) begin
                x_cnt <= '0;
                y_cnt <= y_final;
                if (line_bad) err <= 1'b1;
            end
        end
    end

    // Registered write port and end-of-frame report.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            xpos       <= '0;
            ypos       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en <= pix_valid && keep;
            if (pix_valid && keep) begin
                wr_addr <= addr;
                wr_data <= pix_data;
                xpos    <= x_out;
                ypos    <= y_out;
            end
            frame_done <= (state == ST_DONE);
            frame_err  <= (state == ST_DONE) && (err || line_bad || (y_final != V_LIM));
        end
    end

endmodule

// File: tb/tb_video_capture_rx.sv
// tb_video_capture_rx: scoreboard bench on a reduced 8x4 frame.
module tb_video_capture_rx;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int WP = 10;
    localparam int WA = 19;
    localparam int WC = 12;
`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic          pixel_clk = 1'b0;
    logic          rst_n     = 1'b0;
    logic          vsync_in  = 1'b0;
    logic          href_in   = 1'b0;
    logic [7:0]    data_in   = '0;
    logic          wr_en, busy, frame_done, frame_err;
    logic [WA-1:0] wr_addr;
    logic [WC-1:0] wr_data;
    logic [WP-1:0] xpos, ypos;

    video_capture_rx #(
        .WIDTH_COLOR (WC),
        .WIDTH_POS   (WP),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .WIDTH_ADDR  (WA)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .vsync_in   (vsync_in),
        .href_in    (href_in),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    typedef struct {
        logic [WA-1:0] addr;
        logic [WC-1:0] data;
        logic [WP-1:0] x;
        logic [WP-1:0] y;
        int            cyc;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    logic    fd_q[$];
    wr_exp_t mon_e;
    logic    mon_fe;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model of frame position
    bit capturing = 1'b0;
    bit armed     = 1'b0;
    int fx = 0, fy = 0, faddr = 0;
    bit ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        vsync_in = vs;
        href_in  = hr;
        data_in  = d;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_wr_en"},   32'(wr_en),      0);
        chk({pfx, "_wr_addr"}, 32'(wr_addr),    0);
        chk({pfx, "_wr_data"}, 32'(wr_data),    0);
        chk({pfx, "_xpos"},    32'(xpos),       0);
        chk({pfx, "_ypos"},    32'(ypos),       0);
        chk({pfx, "_busy"},    32'(busy),       0);
        chk({pfx, "_fdone"},   32'(frame_done), 0);
        chk({pfx, "_ferr"},    32'(frame_err),  0);
    endtask

    // Sends one href pulse; rst_at >= 0 pulses rst_n during that pixel's high byte.
    task automatic send_line(input int npix, input bit half, input bit rnd, input int rst_at);
        logic [7:0] hi, lo;
        bit keep;
        for (int p = 0; p < npix; p++) begin
            hi = rnd ? 8'($urandom) : 8'hF8;
            lo = rnd ? 8'($urandom) : 8'h1F;
            if (p == rst_at) begin
                rst_n = 1'b0;
                drive(1'b0, 1'b1, hi);
                wr_q.delete();
                capturing = 1'b0;
                armed     = 1'b0;
                chk_outputs_zero("rst_mid");
                rst_n = 1'b1;
            end else begin
                drive(1'b0, 1'b1, hi);
            end
            if (capturing) begin
                keep = (fx < H) && (fy < V) && (!DS || ((fx % 2 == 0) && (fy % 2 == 0)));
                if (keep) begin
                    wr_q.push_back('{addr: WA'(faddr),
                                     data: {hi[7:4], hi[2:0], lo[7], lo[4:1]},
                                     x:    WP'(DS ? fx / 2 : fx),
                                     y:    WP'(DS ? fy / 2 : fy),
                                     cyc:  cyc + 3});
                    faddr++;
                end
                fx++;
            end
            drive(1'b0, 1'b1, lo);
        end
        if (half) drive(1'b0, 1'b1, 8'hF8);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        if (capturing) begin
            if (half || fx != H) ferr = 1'b1;
            fy++;
            fx = 0;
        end
    endtask

    // vsync high period; closes the frame if one is being captured.
    task automatic vs_high(input int n, input bit noise);
        bit closing;
        closing = capturing;
        if (closing) fd_q.push_back(ferr || (fy != V));
        capturing = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, noise && ((i % 4 == 1) || (i % 4 == 2)), 8'h5A);
            if (closing && i == 2) chk("fdone_latency", 32'(frame_done), 1);
        end
        armed = 1'b1;
    endtask

    task automatic vs_low();
        if (armed) begin
            capturing = 1'b1;
            armed     = 1'b0;
            fx = 0; fy = 0; faddr = 0; ferr = 1'b0;
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("busy", 32'(busy), 32'(capturing));
    endtask

    task automatic frame(input int nlines, input int long_line, input int odd_line,
                         input int rst_line, input bit rnd, input bit noise);
        vs_low();
        for (int l = 0; l < nlines; l++) begin
            if (l == long_line)     send_line(H + 1, 1'b0, rnd, -1);
            else if (l == odd_line) send_line(H - 1, 1'b1, rnd, -1);
            else if (l == rst_line) send_line(H,     1'b0, rnd, 4);
            else                    send_line(H,     1'b0, rnd, -1);
        end
        vs_high(6, noise);
    endtask

    // Output monitor: every write and every frame_done must be expected.
    always @(negedge pixel_clk) begin
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_en), 0);
            end else begin
                mon_e = wr_q.pop_front();
                chk("wr_addr",    32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data",    32'(wr_data), 32'(mon_e.data));
                chk("xpos",       32'(xpos),    32'(mon_e.x));
                chk("ypos",       32'(ypos),    32'(mon_e.y));
                chk("wr_latency", 32'(cyc),     32'(mon_e.cyc));
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                chk("fdone_unexpected", 32'(frame_done), 0);
            end else begin
                mon_fe = fd_q.pop_front();
                chk("frame_err", 32'(frame_err), 32'(mon_fe));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        vs_high(6, 1'b0);
        frame(V,     -1, -1, -1, 1'b0, 1'b0);  // clean frame, 0xF8/0x1F -> 0xF0F
        frame(V,      1, -1, -1, 1'b1, 1'b1);  // one line too long, href noise in vsync
        frame(V,     -1,  2, -1, 1'b1, 1'b0);  // odd byte count on line 2
        frame(V + 1, -1, -1, -1, 1'b1, 1'b0);  // extra line is not written
        frame(V - 1, -1, -1, -1, 1'b1, 1'b0);  // short frame
        frame(V,     -1, -1,  2, 1'b1, 1'b0);  // reset mid-line: frame discarded
        frame(V,     -1, -1, -1, 1'b1, 1'b0);  // clean frame restarts at address 0
        repeat (6) drive(1'b0, 1'b0, 8'h00);

        chk("wr_pending", 32'(wr_q.size()), 0);
        chk("fd_pending", 32'(fd_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
